iterative_shift_unit: RTL and testbench

Multi-cycle shifter complementing the team's combinational mux-tree right shifter: it takes a word, a shift amount and a mode through a valid/ready handshake and shifts one bit position per clock. It supports left shifts, which the combinational shifter lacks, plus logical and arithmetic right shifts, and returns the result through a second valid/ready handshake. It sits between a register-file read port and the write-back path in the datapath, where area matters more than latency.

---
 rtl/shift_pkg.sv | 15 +
 rtl/iterative_shift_unit_if.sv | 26 ++
 rtl/shift_step.sv | 23 ++
 rtl/iterative_shift_unit.sv | 77 +++++++
 tb/tb_iterative_shift_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter: shift-mode encodings and FSM states.
package shift_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_LSR = 2'b10;
  localparam logic [1:0] MODE_ASR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/iterative_shift_unit_if.sv
// Request/result handshake bundle for the iterative shifter.
interface iterative_shift_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/shift_step.sv
// One-bit shift/rotate stage; the iterative shifter applies it once per SHIFT cycle.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] w,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] w_next
);

  always_comb begin
    w_next = w;
    case (mode)
      MODE_LSL: w_next = {w[WIDTH-2:0], 1'b0};
      MODE_ROL: w_next = {w[WIDTH-2:0], w[WIDTH-1]};
      MODE_LSR: w_next = {1'b0, w[WIDTH-1:1]};
      MODE_ASR: w_next = {w[WIDTH-1], w[WIDTH-1:1]};
      default:  w_next = w;
    endcase
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shifter: accepts word/amount/mode, shifts one bit per clock, returns the result
// through a valid/ready handshake. All outputs come from registers or decoded state.
module iterative_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic                  clk,
  input logic                  rst_n,
  iterative_shift_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] step_w;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .w      (work_q),
    .mode   (mode_q),
    .w_next (step_w)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_data;
          cnt_d   = bus.in_amt;
          mode_d  = bus.in_mode;
          state_d = (bus.in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // Counter is nonzero throughout SHIFT, so the decrement cannot wrap.
        work_d = step_w;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_LSL;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = work_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Bench for iterative_shift_unit: directed latency/result steps plus a randomized
// back-to-back run scored against an arithmetic shift model.
module tb_iterative_shift_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SHW   = 3;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  iterative_shift_unit_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  iterative_shift_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a,
                                           input logic [1:0] m);
    logic signed [7:0] s;
    s = d;
    case (m)
      2'b00:   return d << a;
      2'b01:   return (d << a) | (d >> (8 - a));
      2'b10:   return d >> a;
      default: return s >>> a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request and return just after its acceptance edge.
  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("send_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_mode  = m;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid is visible.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] d, input logic [2:0] a,
                        input logic [1:0] m, input logic [7:0] exp_data);
    int cycles;
    bus.out_ready = 1'b1;
    send(d, a, m);
    wait_valid(cycles);
    check({tag, "_latency"}, 32'(cycles), 32'(a));
    check({tag, "_data"}, 32'(bus.out_data), 32'(exp_data));
    @(posedge clk); #1;
    check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int          cycles;
    int          seen_valid;
    int          sent;
    int          got;
    int          cyc;
    logic        acc;
    logic        take;
    logic [7:0]  expq[$];
    logic [7:0]  exp_v;
    logic [7:0]  rd;
    logic [2:0]  ra;
    logic [1:0]  rm;

    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;

    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an LSL 0x81 by 5.
    send(8'h81, 3'd5, 2'b00);
    @(posedge clk); #1;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data", 32'(bus.out_data), 32'd0);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_valid++;
    end
    check("midrst_no_result", 32'(seen_valid), 32'd0);

    run_op("lsl_81_3", 8'h81, 3'd3, 2'b00, 8'h08);
    run_op("lsr_81_3", 8'h81, 3'd3, 2'b10, 8'h10);
    run_op("rol_81_1", 8'h81, 3'd1, 2'b01, 8'h03);
    run_op("rol_81_7", 8'h81, 3'd7, 2'b01, 8'hC0);
    run_op("asr_90_4", 8'h90, 3'd4, 2'b11, 8'hF9);
    run_op("asr_70_4", 8'h70, 3'd4, 2'b11, 8'h07);
    run_op("lsl_a5_0", 8'hA5, 3'd0, 2'b00, 8'hA5);

    // Backpressure: result held while new requests are offered and ignored.
    bus.out_ready = 1'b0;
    send(8'h81, 3'd3, 2'b00);
    wait_valid(cycles);
    check("bp_latency", 32'(cycles), 32'd3);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom);
      bus.in_amt   = 3'($urandom);
      bus.in_mode  = 2'($urandom);
      @(posedge clk); #1;
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data", 32'(bus.out_data), 32'h08);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_taken", 32'(bus.out_valid), 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_valid++;
    end
    check("bp_taken_once", 32'(seen_valid), 32'd0);

    // Back-to-back random requests with random consumer readiness.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 20 && cyc < 3000) begin
      if (!bus.in_valid && sent < 20) begin
        rd = 8'($urandom);
        ra = 3'($urandom_range(0, 7));
        rm = 2'($urandom_range(0, 3));
        bus.in_valid = 1'b1;
        bus.in_data  = rd;
        bus.in_amt   = ra;
        bus.in_mode  = rm;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      acc  = bus.in_valid && bus.in_ready;
      take = bus.out_valid && bus.out_ready;
      if (acc) begin
        expq.push_back(ref_shift(bus.in_data, int'(bus.in_amt), bus.in_mode));
        sent++;
      end
      if (take) begin
        if (expq.size() == 0) begin
          check("b2b_unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_v = expq.pop_front();
          check("b2b_data", 32'(bus.out_data), 32'(exp_v));
        end
        got++;
      end
      @(posedge clk); #1;
      if (acc) bus.in_valid = 1'b0;
      cyc++;
    end
    check("b2b_results", 32'(got), 32'd20);
    check("b2b_drained", 32'(expq.size()), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
